reconfig_timer_bank: RTL and testbench
======================================

// Module: reconfig_timer_bank
// PURPOSE
//  Multi-channel, parametrised successor to the single reconfigurable game timer.
//  Each channel is a countdown loaded from a per-channel config code, with pause/resume
//  and optional auto-reload. Ticks come from one shared prescaler.
//  Sits between the game FSM (start/stop/config) and the display and scoring logic
//  (remaining, time_out).
// PARAMETERS
//  NUM_CH      2    number of independent timer channels
//  CFG_W       4    width of each channel's reconfig code
//  UNIT_TICKS  100  ticks per config unit; load value = code * UNIT_TICKS
//  PRESCALE    50   clock cycles per tick (>=1; 1 = tick every cycle)
//  CNT_W       16   counter width; must hold (2**CFG_W-1)*UNIT_TICKS
// PORTS
//  clock      in   1             system clock, rising edge
//  rst        in   1             asynchronous, active-high reset
//  start      in   NUM_CH        per-channel pulse: latch config, load and run
//  stop_in    in   NUM_CH        per-channel pulse: pause (hold count)
//  resume     in   NUM_CH        per-channel pulse: continue a paused count
//  mode       in   NUM_CH        sampled at start: 0 = one-shot, 1 = auto-reload
//  reconfig   in   NUM_CH*CFG_W  config code; channel c = [c*CFG_W +: CFG_W], sampled at start
//  busy       out  NUM_CH        channel in RUN or PAUSED
//  time_out   out  NUM_CH        one-cycle expiry pulse, registered
//  remaining  out  NUM_CH*CNT_W  current count per channel, registered
// BEHAVIOUR
//  - Reset (async, any time, including mid-count): all outputs 0, all channels IDLE,
//    prescaler 0, latched mode/load cleared.
//  - Prescaler: free-running 0..PRESCALE-1; tick=1 for one cycle when it wraps.
//    Shared by all channels; it does not restart on start.
//  - Per-channel states: IDLE, RUN, PAUSED.
//  - Input priority per channel, same cycle: start > stop_in > resume.
//  - start (any state, including RUN):
//      load = reconfig_c * UNIT_TICKS; latch load and mode.
//      After that edge: remaining = load, state RUN, busy = 1.
//  - start with code 0: remaining = 0, state IDLE, busy = 0, and time_out pulses on
//    the same edge (1-cycle latency).
//  - RUN on tick:
//      remaining > 1 -> remaining - 1.
//      remaining == 1 -> expire: time_out = 1 for exactly one cycle.
//        one-shot: remaining = 0, state IDLE, busy = 0.
//        auto-reload: remaining = latched load, stay RUN.
//  - stop_in in RUN -> PAUSED; count frozen, busy stays 1.
//    stop_in in IDLE or PAUSED is ignored.
//  - resume in PAUSED -> RUN; counting continues on the next tick.
//    resume in other states is ignored.
//  - A stop_in that lands on an expiring tick loses: the expiry happens,
//    then the pause applies only if a reload kept the channel running.
//  - Mid-count changes to reconfig/mode have no effect until the next start.
//  - No arithmetic wrap: remaining never goes below 0. The multiply is done at
//    CNT_W width; the elaboration-time check on CNT_W is mandatory.
//  - Channels are fully independent; simultaneous events on different channels
//    are all honoured in the same cycle.
// STRUCTURE
//  - timer_defs.vh: state encodings (ST_IDLE/ST_RUN/ST_PAUSED) and mode constants
//    (MODE_ONESHOT/MODE_RELOAD).
//  - Sub-module timer_channel: one FSM plus counter, instantiated NUM_CH times in a
//    generate loop.
//  - Top holds only the prescaler and the port slicing.
// TESTING  (PRESCALE=4, UNIT_TICKS=10, NUM_CH=2)
//  1. start ch0, code 4'b1010, mode 0
//     -> remaining=100 next cycle; time_out[0] pulses after 100 ticks (~400 clk);
//        busy[0] drops with it.
//  2. start ch0 (code 3); stop_in after 5 ticks; wait 2000 clk; resume
//     -> remaining holds 25 while paused; expiry 25 ticks after resume.
//  3. start ch1, code 2, mode 1
//     -> time_out[1] pulses every 20 ticks (80 clk); busy[1] stays 1;
//        a later start reloads with the new code.
//  4. start ch0 with code 0 -> time_out[0] one cycle later, busy[0]=0.
//     start and stop_in in the same cycle -> start wins.
//  5. rst asserted mid-count, away from a clock edge
//     -> all outputs 0 immediately; no time_out after rst is released.
//  6. both channels start the same cycle with codes 1 and 2
//     -> independent expiries at 10 and 20 ticks.

Source files
------------

// File: rtl/reconfig_timer_bank_pkg.sv
// Shared definitions for the reconfigurable timer bank.
//   ch_state_e   : per-channel state encoding (idle / counting / paused)
//   MODE_*       : values of the mode input latched at start
//   pre_width()  : prescaler counter width, at least one bit
package reconfig_timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } ch_state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // A prescale of 1 still needs a one-bit counter register.
  function automatic int unsigned pre_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/reconfig_timer_bank_channel.sv
// One countdown channel: IDLE/RUN/PAUSED FSM plus counter.
// Ports:
//   clock, rst        clock and asynchronous active-high reset
//   tick              shared prescaler tick (combinational, one cycle wide)
//   start/stop_in/resume  command pulses, priority start > stop_in > resume
//   mode, code        sampled only on start
//   busy              registered, high in RUN or PAUSED
//   time_out          registered one-cycle expiry pulse
//   remaining         registered current count
module reconfig_timer_bank_channel
  import reconfig_timer_bank_pkg::*;
#(
  parameter int unsigned CFG_W      = 4,
  parameter int unsigned UNIT_TICKS = 100,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop_in,
  input  logic             resume,
  input  logic             mode,
  input  logic [CFG_W-1:0] code,
  output logic             busy,
  output logic             time_out,
  output logic [CNT_W-1:0] remaining
);

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] load_q, load_n;
  logic             mode_q, mode_n;
  logic             time_out_n;
  logic [CNT_W-1:0] start_load_c;
  logic             expire_c;

  // Multiply kept at counter width; the top guarantees it cannot overflow.
  assign start_load_c = CNT_W'(code) * CNT_W'(UNIT_TICKS);
  assign expire_c     = tick && (remaining == CNT_W'(1));

  // State and output registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      load_q    <= '0;
      mode_q    <= MODE_ONESHOT;
      time_out  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= count_n;
      load_q    <= load_n;
      mode_q    <= mode_n;
      time_out  <= time_out_n;
      busy      <= (state_n != ST_IDLE);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_n    = state;
    count_n    = remaining;
    load_n     = load_q;
    mode_n     = mode_q;
    time_out_n = 1'b0;

    if (start) begin
      load_n  = start_load_c;
      mode_n  = mode;
      count_n = start_load_c;
      if (start_load_c == '0) begin
        state_n    = ST_IDLE;
        time_out_n = 1'b1;
      end else begin
        state_n = ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (expire_c) begin
            // Expiry beats a coincident stop; the pause only sticks after a reload.
            time_out_n = 1'b1;
            if (mode_q == MODE_RELOAD) begin
              count_n = load_q;
              if (stop_in) state_n = ST_PAUSED;
            end else begin
              count_n = '0;
              state_n = ST_IDLE;
            end
          end else if (stop_in) begin
            state_n = ST_PAUSED;
          end else if (tick && (remaining != '0)) begin
            count_n = remaining - CNT_W'(1);
          end
        end
        ST_PAUSED: begin
          // A simultaneous stop_in outranks resume and keeps the channel paused.
          if (!stop_in && resume) state_n = ST_RUN;
        end
        ST_IDLE: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reconfig_timer_bank.sv
// Multi-channel reconfigurable countdown timer bank with a shared prescaler.
// Ports:
//   clock, rst   clock and asynchronous active-high reset
//   start        per-channel: latch config, load and run
//   stop_in      per-channel: pause
//   resume       per-channel: continue a paused count
//   mode         per-channel, 0 = one-shot, 1 = auto-reload (sampled at start)
//   reconfig     channel c code at [c*CFG_W +: CFG_W] (sampled at start)
//   busy         per-channel RUN or PAUSED
//   time_out     per-channel one-cycle expiry pulse
//   remaining    channel c count at [c*CNT_W +: CNT_W]
module reconfig_timer_bank
  import reconfig_timer_bank_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CFG_W      = 4,
  parameter int unsigned UNIT_TICKS = 100,
  parameter int unsigned PRESCALE   = 50,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop_in,
  input  logic [NUM_CH-1:0]       resume,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CFG_W-1:0] reconfig,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       time_out,
  output logic [NUM_CH*CNT_W-1:0] remaining
);

  localparam int unsigned     PRE_W    = pre_width(PRESCALE);
  localparam longint unsigned MAX_LOAD = ((64'd1 << CFG_W) - 64'd1) * 64'(UNIT_TICKS);
  localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

  // Elaboration-time parameter checks.
  if (MAX_LOAD > CNT_MAX) begin : g_cnt_w_too_narrow
    $error("reconfig_timer_bank: CNT_W cannot hold the largest load value");
  end
  if (PRESCALE < 1) begin : g_prescale_zero
    $error("reconfig_timer_bank: PRESCALE must be at least 1");
  end

  logic [PRE_W-1:0] pre_cnt;
  logic             tick_c;

  assign tick_c = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Free-running prescaler shared by every channel; start does not realign it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)         pre_cnt <= '0;
    else if (tick_c) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + PRE_W'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    reconfig_timer_bank_channel #(
      .CFG_W      (CFG_W),
      .UNIT_TICKS (UNIT_TICKS),
      .CNT_W      (CNT_W)
    ) u_channel (
      .clock     (clock),
      .rst       (rst),
      .tick      (tick_c),
      .start     (start[c]),
      .stop_in   (stop_in[c]),
      .resume    (resume[c]),
      .mode      (mode[c]),
      .code      (reconfig[c*CFG_W +: CFG_W]),
      .busy      (busy[c]),
      .time_out  (time_out[c]),
      .remaining (remaining[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_reconfig_timer_bank.sv
// Bench for reconfig_timer_bank: vector table, hand sequences and random stimulus,
// all outputs checked every cycle against a behavioural model.
module tb_reconfig_timer_bank;

  localparam int NUM_CH     = 2;
  localparam int CFG_W      = 4;
  localparam int UNIT_TICKS = 10;
  localparam int PRESCALE   = 4;
  localparam int CNT_W      = 16;

  logic                    clock = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       start, stop_in, resume, mode;
  logic [NUM_CH*CFG_W-1:0] reconfig;
  logic [NUM_CH-1:0]       busy, time_out;
  logic [NUM_CH*CNT_W-1:0] remaining;

  reconfig_timer_bank #(
    .NUM_CH(NUM_CH), .CFG_W(CFG_W), .UNIT_TICKS(UNIT_TICKS),
    .PRESCALE(PRESCALE), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .stop_in(stop_in), .resume(resume),
    .mode(mode), .reconfig(reconfig), .busy(busy), .time_out(time_out),
    .remaining(remaining)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a channel is "active" while it has a live countdown.
  int m_rem[NUM_CH], m_load[NUM_CH];
  bit m_act[NUM_CH], m_pause[NUM_CH], m_reload[NUM_CH], m_to[NUM_CH];
  int m_pre;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_rem[c] = 0; m_load[c] = 0; m_act[c] = 0; m_pause[c] = 0; m_reload[c] = 0; m_to[c] = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit tick;
    int code;
    tick  = (m_pre == PRESCALE - 1);
    m_pre = (m_pre + 1) % PRESCALE;
    for (int c = 0; c < NUM_CH; c++) begin
      m_to[c] = 0;
      code = int'(reconfig[c*CFG_W +: CFG_W]);
      if (start[c]) begin
        m_load[c]   = code * UNIT_TICKS;
        m_reload[c] = mode[c];
        m_rem[c]    = m_load[c];
        m_pause[c]  = 0;
        m_act[c]    = (m_load[c] != 0);
        if (m_load[c] == 0) m_to[c] = 1;
      end else if (m_act[c] && !m_pause[c]) begin
        if (tick && m_rem[c] == 1) begin
          m_to[c] = 1;
          if (m_reload[c]) begin
            m_rem[c]   = m_load[c];
            m_pause[c] = stop_in[c];
          end else begin
            m_rem[c] = 0;
            m_act[c] = 0;
          end
        end else if (stop_in[c]) begin
          m_pause[c] = 1;
        end else if (tick) begin
          m_rem[c] = m_rem[c] - 1;
        end
      end else if (m_act[c] && m_pause[c] && !stop_in[c] && resume[c]) begin
        m_pause[c] = 0;
      end
    end
  endtask

  task automatic compare_model();
    logic [NUM_CH*CNT_W-1:0] er;
    logic [NUM_CH-1:0]       eb, et;
    for (int c = 0; c < NUM_CH; c++) begin
      er[c*CNT_W +: CNT_W] = CNT_W'(m_rem[c]);
      eb[c] = m_act[c];
      et[c] = m_to[c];
    end
    check("model_remaining", 64'(remaining), 64'(er));
    check("model_busy",      64'(busy),      64'(eb));
    check("model_time_out",  64'(time_out),  64'(et));
  endtask

  // Drive one cycle of inputs, clock it, then compare away from the edge.
  task automatic step(input logic [1:0] s, input logic [1:0] p, input logic [1:0] r,
                      input logic [1:0] md, input logic [7:0] cfg);
    start = s; stop_in = p; resume = r; mode = md; reconfig = cfg;
    model_edge();
    @(posedge clock);
    #1;
    compare_model();
    start = '0; stop_in = '0; resume = '0;
  endtask

  typedef struct {
    logic [1:0]  s, p, r, md;
    logic [7:0]  cfg;
    int          cycles;
    logic [15:0] rem0, rem1;
    logic [1:0]  busy, to;
  } vec_t;

  vec_t vt[$];

  initial begin
    int  n;
    bit  seen;
    logic [1:0] s, p, r, md;
    logic [7:0] cfg;

    start = '0; stop_in = '0; resume = '0; mode = '0; reconfig = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_remaining", 64'(remaining), 64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_time_out",  64'(time_out),  64'd0);
    rst = 1'b0;

    // Edge numbers below count from the first edge after reset release.
    //           s      p      r      md     cfg    cyc rem0 rem1 busy   to
    vt.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 8'h0A, 1,  100, 0,  2'b01, 2'b00}); // start 100
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 8'h0A, 7,  98,  0,  2'b01, 2'b00}); // ticks at 4,8
    vt.push_back('{2'b00, 2'b01, 2'b00, 2'b00, 8'h0A, 1,  98,  0,  2'b01, 2'b00}); // pause
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 8'h0A, 20, 98,  0,  2'b01, 2'b00}); // held
    vt.push_back('{2'b00, 2'b00, 2'b01, 2'b00, 8'h0A, 1,  98,  0,  2'b01, 2'b00}); // resume
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 8'h0A, 2,  97,  0,  2'b01, 2'b00}); // tick at 32
    vt.push_back('{2'b10, 2'b01, 2'b00, 2'b10, 8'h2A, 1,  97,  20, 2'b11, 2'b00}); // ch1 reload 20
    vt.push_back('{2'b01, 2'b01, 2'b00, 2'b10, 8'h20, 1,  0,   20, 2'b10, 2'b01}); // code 0 + stop
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b10, 8'h20, 1,  0,   20, 2'b10, 2'b00});
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b10, 8'h20, 77, 0,   20, 2'b10, 2'b10}); // reload at 112
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b10, 8'h20, 1,  0,   20, 2'b10, 2'b00});
    vt.push_back('{2'b10, 2'b00, 2'b00, 2'b00, 8'h10, 1,  0,   10, 2'b10, 2'b00}); // restart one-shot
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 8'h10, 38, 0,   0,  2'b00, 2'b10}); // expire at 152
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 8'h10, 1,  0,   0,  2'b00, 2'b00});
    vt.push_back('{2'b01, 2'b00, 2'b00, 2'b01, 8'h01, 1,  10,  0,  2'b01, 2'b00}); // ch0 reload 10
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b01, 8'h01, 37, 1,   0,  2'b01, 2'b00});
    vt.push_back('{2'b00, 2'b01, 2'b00, 2'b01, 8'h01, 1,  10,  0,  2'b01, 2'b01}); // stop on expiry
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b01, 8'h01, 8,  10,  0,  2'b01, 2'b00}); // paused after reload
    vt.push_back('{2'b00, 2'b00, 2'b01, 2'b01, 8'h01, 1,  10,  0,  2'b01, 2'b00});
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b01, 8'h01, 3,  9,   0,  2'b01, 2'b00}); // tick at 204
    vt.push_back('{2'b11, 2'b00, 2'b00, 2'b00, 8'h21, 1,  10,  20, 2'b11, 2'b00}); // both start
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 8'h21, 39, 0,   10, 2'b10, 2'b01}); // ch0 at 10 ticks
    vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 8'h21, 40, 0,   0,  2'b00, 2'b10}); // ch1 at 20 ticks

    foreach (vt[i]) begin
      step(vt[i].s, vt[i].p, vt[i].r, vt[i].md, vt[i].cfg);
      for (int k = 1; k < vt[i].cycles; k++) step(2'b00, 2'b00, 2'b00, vt[i].md, vt[i].cfg);
      check($sformatf("vec%0d_rem0", i), 64'(remaining[15:0]),  64'(vt[i].rem0));
      check($sformatf("vec%0d_rem1", i), 64'(remaining[31:16]), 64'(vt[i].rem1));
      check($sformatf("vec%0d_busy", i), 64'(busy),             64'(vt[i].busy));
      check($sformatf("vec%0d_to",   i), 64'(time_out),         64'(vt[i].to));
    end

    // One-shot of 100 ticks: expiry lands 397..400 cycles after the start edge.
    step(2'b01, 2'b00, 2'b00, 2'b00, 8'h0A);
    n = 0;
    seen = 0;
    while (!seen && n < 500) begin
      step(2'b00, 2'b00, 2'b00, 2'b00, 8'h0A);
      n++;
      seen = time_out[0];
    end
    check("expiry_latency_in_window", 64'(seen && n >= 397 && n <= 400), 64'd1);
    check("busy_drops_with_expiry",   64'(busy[0]), 64'd0);

    // Asynchronous reset in the middle of a count, away from any edge.
    step(2'b11, 2'b00, 2'b00, 2'b11, 8'hFF);
    repeat (50) step(2'b00, 2'b00, 2'b00, 2'b11, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_remaining", 64'(remaining), 64'd0);
    check("async_rst_busy",      64'(busy),      64'd0);
    check("async_rst_time_out",  64'(time_out),  64'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      step(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
      if (time_out != '0) seen = 1;
    end
    check("no_time_out_after_rst", 64'(seen), 64'd0);

    // Random traffic; reconfig/mode churn every cycle to show they only matter at start.
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s[c]  = ($urandom_range(0, 199) == 0);
        p[c]  = ($urandom_range(0, 39) == 0);
        r[c]  = ($urandom_range(0, 19) == 0);
        md[c] = 1'($urandom_range(0, 1));
        cfg[c*4 +: 4] = 4'($urandom_range(0, 4));
      end
      step(s, p, r, md, cfg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
